// File: rtl/parity_check_rx_if.sv
// Serial parity link, receive side: line bits in, decoded word and status out.
// The master modport drives the line; the slave modport is the receiver.
interface parity_check_rx_if #(
   parameter int DATA_W = 3,
   parameter int CNT_W  = 8
);
   logic              bit_valid;
   logic              bit_in;
   logic              odd_sel;
   logic              busy;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              parity_err;
   logic              frame_err;
   logic [CNT_W-1:0]  err_cnt;

   modport master (
      output bit_valid, bit_in, odd_sel,
      input  busy, data_out, data_valid, parity_err, frame_err, err_cnt
   );

   modport slave (
      input  bit_valid, bit_in, odd_sel,
      output busy, data_out, data_valid, parity_err, frame_err, err_cnt
   );
endinterface

// File: rtl/parity_check_rx.sv
// Parity link receiver: deframes start/DATA_W data/parity/stop, checks parity
// against the odd_sel value latched at the start bit, and counts parity errors.
module parity_check_rx #(
   parameter int DATA_W = 3,
   parameter int CNT_W  = 8
) (
   input logic              clk,
   input logic              rst,
   parity_check_rx_if.slave link
);
   localparam int BIT_CNT_W = $clog2(DATA_W + 1);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t                state_q, state_nxt;
   logic [DATA_W-1:0]     shift_q;
   logic [BIT_CNT_W-1:0]  bit_cnt_q;
   logic                  odd_q;
   logic                  rx_p_q;
   logic [DATA_W-1:0]     data_out_q;
   logic                  data_valid_q;
   logic                  parity_err_q;
   logic                  frame_err_q;
   logic [CNT_W-1:0]      err_cnt_q;
   logic                  parity_bad;

   // Parity check of the frame currently sitting in STOP.
   assign parity_bad = rx_p_q != (^shift_q ^ odd_q);

   always_comb begin
      // NOTE: default assigned first so no path through the case leaves state_nxt unassigned (no latch).
      state_nxt = state_q;
      if (link.bit_valid) begin
         case (state_q)
            IDLE:    if (!link.bit_in) state_nxt = DATA;
            DATA:    if (bit_cnt_q == LAST_BIT) state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (rst) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         odd_q        <= 1'b0;
         rx_p_q       <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_nxt;
         data_valid_q <= 1'b0;
         if (link.bit_valid) begin
            case (state_q)
               IDLE: begin
                  if (!link.bit_in) begin
                     odd_q     <= link.odd_sel;
                     shift_q   <= '0;
                     bit_cnt_q <= '0;
                  end
               end
               DATA: begin
                  shift_q   <= (shift_q << 1) | DATA_W'(link.bit_in);
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
               PARITY: rx_p_q <= link.bit_in;
               STOP: begin
                  data_out_q   <= shift_q;
                  parity_err_q <= parity_bad;
                  frame_err_q  <= ~link.bit_in;
                  data_valid_q <= 1'b1;
                  if (parity_bad && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign link.busy       = (state_q != IDLE);
   assign link.data_out   = data_out_q;
   assign link.data_valid = data_valid_q;
   assign link.parity_err = parity_err_q;
   assign link.frame_err  = frame_err_q;
   assign link.err_cnt    = err_cnt_q;
endmodule
